// File: rtl/frost32_mem_arbiter.sv
// Frost32 memory arbiter: one variable-latency bus shared by fetch
// and load/store, with starvation guard, alignment checks and timeout.
module frost32_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_access_type,
    input  logic [1:0]            d_access_size,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_access_type,
    output logic [1:0]            mem_access_size,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StData,
        StErr
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] streak;
    logic [TW-1:0] timer;
    logic          idle;
    logic          d_win;
    logic          d_bad;
    logic          if_bad;
    logic          done;
    logic          tmo;

    // Grants are combinational but forced low while reset is held.
    assign idle   = rst_n && (state == StIdle);
    assign d_win  = !if_req || (streak != STREAK_MAX);
    assign d_gnt  = idle && d_req && d_win;
    assign if_gnt = idle && if_req && !(d_req && d_win);
    assign busy   = (state != StIdle);

    assign d_bad  = (d_access_size == 2'd3)
                 || ((d_access_size == 2'd0)
                     && (d_addr[1:0] != 2'b00))
                 || ((d_access_size == 2'd1)
                     && d_addr[0]);
    assign if_bad = (if_addr[1:0] != 2'b00);

    assign done = mem_req && mem_ready;
    assign tmo  = mem_req && !mem_ready
               && (timer == TIMER_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            StIdle: begin
                if (d_gnt) begin
                    state_nx = d_bad ? StErr : StData;
                end else if (if_gnt) begin
                    state_nx = if_bad ? StErr : StFetch;
                end
            end
            StFetch, StData: begin
                if (done || tmo) begin
                    state_nx = StIdle;
                end
            end
            StErr:   state_nx = StIdle;
            default: state_nx = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak          <= '0;
            timer           <= '0;
            if_valid        <= 1'b0;
            if_rdata        <= '0;
            if_err          <= 1'b0;
            d_valid         <= 1'b0;
            d_rdata         <= '0;
            d_err           <= 1'b0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_access_type <= 1'b0;
            mem_access_size <= 2'd0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;

            // Fetch starvation guard: count data wins while fetch waits.
            if (!if_req || if_gnt) begin
                streak <= '0;
            end else if (d_gnt && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end

            unique case (state)
                StIdle: begin
                    timer <= '0;
                    if (d_gnt) begin
                        if (d_bad) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            mem_req         <= 1'b1;
                            mem_addr        <= d_addr;
                            mem_wdata       <= d_wdata;
                            mem_access_type <= d_access_type;
                            mem_access_size <= d_access_size;
                        end
                    end else if (if_gnt) begin
                        if (if_bad) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                        end else begin
                            mem_req         <= 1'b1;
                            mem_addr        <= if_addr;
                            mem_wdata       <= '0;
                            mem_access_type <= 1'b0;
                            mem_access_size <= 2'd0;
                        end
                    end
                end
                StFetch: begin
                    if (done) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else if (tmo) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                    end else if (mem_req) begin
                        timer <= timer + 1'b1;
                    end
                end
                StData: begin
                    if (done) begin
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= mem_access_type
                                   ? '0 : mem_rdata;
                    end else if (tmo) begin
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= '0;
                    end else if (mem_req) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Directed self-checking bench for frost32_mem_arbiter.
// Memory responder raises mem_ready after lat wait cycles (lat<0: never).
module tb_frost32_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_access_type = 1'b0;
    logic [1:0]    d_access_size = 2'd0;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_access_type;
    logic [1:0]    mem_access_size;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int            vec = 0;
    int            bad = 0;
    int            lat = 0;
    int            wcnt = 0;
    logic [DW-1:0] rd_val = '0;

    frost32_mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_DATA_STREAK(4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_valid       (if_valid),
        .if_rdata       (if_rdata),
        .if_err         (if_err),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_access_type  (d_access_type),
        .d_access_size  (d_access_size),
        .d_gnt          (d_gnt),
        .d_valid        (d_valid),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_access_type(mem_access_type),
        .mem_access_size(mem_access_size),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        mem_ready = mem_req && (lat >= 0) && (wcnt == lat);
        if (mem_req) wcnt = wcnt + 1;
        else wcnt = 0;
        mem_rdata = rd_val;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_req  = 1'b1;
        if_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({if_gnt, d_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL reset_gnt got %b want 00",
                     {if_gnt, d_gnt});
        end
        vec++;
        if ({mem_req, busy, if_valid, d_valid,
             if_err, d_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got %b want 0",
                     {mem_req, busy, if_valid, d_valid,
                      if_err, d_err});
        end
        vec++;
        if ({mem_addr, mem_wdata, mem_access_type,
             mem_access_size} !== '0) begin
            bad++;
            $display("FAIL reset_bus got %h %h want 0",
                     mem_addr, mem_wdata);
        end
        vec++;
        if ({if_rdata, d_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_rdata got %h %h want 0",
                     if_rdata, d_rdata);
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_read();
        lat    = 0;
        rd_val = 32'hDEADBEEF;
        d_req  = 1'b1;
        d_addr = 32'h100;
        d_access_type = 1'b0;
        d_access_size = 2'd0;
        #1;
        vec++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL read_gnt got %b want 10",
                     {d_gnt, if_gnt});
        end
        cyc();
        d_req = 1'b0;
        #1;
        vec++;
        if ({mem_req, d_valid, busy} !== 3'b101
            || mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL read_bus got %b %h want 101 100",
                     {mem_req, d_valid, busy}, mem_addr);
        end
        cyc();
        #1;
        vec++;
        if ({d_valid, d_err, mem_req} !== 3'b100
            || d_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_valid got %b %h want 100 deadbeef",
                     {d_valid, d_err, mem_req}, d_rdata);
        end
        cyc();
        #1;
        vec++;
        if ({d_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL read_end got %b want 00",
                     {d_valid, busy});
        end
    endtask

    task automatic test_arbitration();
        string seq;
        string exp;
        seq = "";
        exp = "DDDDFDDDDF";
        lat = 0;
        rd_val = 32'h12345678;
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h400;
        d_req   = 1'b1;
        d_addr  = 32'h500;
        d_access_type = 1'b0;
        d_access_size = 2'd0;
        for (int c = 0; c < 20; c++) begin
            #1;
            vec++;
            if (if_gnt && d_gnt) begin
                bad++;
                $display("FAIL arb_both cycle %0d got 11 want <=1", c);
            end
            if (d_gnt) seq = {seq, "D"};
            else if (if_gnt) seq = {seq, "F"};
            cyc();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        vec++;
        if (seq.len() != 10) begin
            bad++;
            $display("FAIL arb_count got %0d want 10", seq.len());
        end
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (i >= seq.len() || seq[i] != exp[i]) begin
                bad++;
                $display("FAIL arb_order got %s want %s", seq, exp);
            end
        end
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_bad_access();
        logic [AW-1:0] addrs [3];
        logic [1:0]    sizes [3];
        addrs[0] = 32'h100;
        addrs[1] = 32'h101;
        addrs[2] = 32'h402;
        sizes[0] = 2'd3;
        sizes[1] = 2'd1;
        sizes[2] = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 2) begin
                if_req  = 1'b1;
                if_addr = addrs[k];
            end else begin
                d_req  = 1'b1;
                d_addr = addrs[k];
                d_access_size = sizes[k];
            end
            #1;
            vec++;
            if ((k == 2 ? if_gnt : d_gnt) !== 1'b1) begin
                bad++;
                $display("FAIL bad_gnt case %0d got 0 want 1", k);
            end
            cyc();
            d_req  = 1'b0;
            if_req = 1'b0;
            #1;
            vec++;
            if (k == 2) begin
                if ({if_valid, if_err, mem_req, busy} !== 4'b1101
                    || if_rdata !== '0) begin
                    bad++;
                    $display("FAIL bad_if got %b %h want 1101 0",
                             {if_valid, if_err, mem_req, busy},
                             if_rdata);
                end
            end else begin
                if ({d_valid, d_err, mem_req, busy} !== 4'b1101
                    || d_rdata !== '0) begin
                    bad++;
                    $display("FAIL bad_d case %0d got %b %h want 1101 0",
                             k, {d_valid, d_err, mem_req, busy},
                             d_rdata);
                end
            end
            cyc();
            #1;
            vec++;
            if ({d_valid, if_valid, mem_req, busy} !== 4'b0) begin
                bad++;
                $display("FAIL bad_end case %0d got %b want 0000",
                         k, {d_valid, if_valid, mem_req, busy});
            end
        end
    endtask

    task automatic test_write();
        lat    = 5;
        rd_val = 32'hCAFEF00D;
        cyc();
        d_req  = 1'b1;
        d_addr = 32'h203;
        d_wdata = 32'h55;
        d_access_type = 1'b1;
        d_access_size = 2'd2;
        #1;
        vec++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL wr_gnt got %b want 1", d_gnt);
        end
        cyc();
        d_req = 1'b0;
        d_wdata = 32'h0;
        d_addr  = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            vec++;
            if ({mem_req, mem_addr, mem_wdata, mem_access_type,
                 mem_access_size, d_valid} !==
                {1'b1, 32'h203, 32'h55, 1'b1, 2'd2, 1'b0}) begin
                bad++;
                $display("FAIL wr_hold cyc %0d got %b %h %h %b %b",
                         k, mem_req, mem_addr, mem_wdata,
                         mem_access_type, mem_access_size);
            end
            cyc();
        end
        #1;
        vec++;
        if ({d_valid, d_err, mem_req} !== 3'b100
            || d_rdata !== '0) begin
            bad++;
            $display("FAIL wr_done got %b %h want 100 0",
                     {d_valid, d_err, mem_req}, d_rdata);
        end
        d_access_type = 1'b0;
        d_access_size = 2'd0;
        cyc();
    endtask

    task automatic test_timeout();
        lat = -1;
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1;
        vec++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL to_gnt got %b want 1", if_gnt);
        end
        cyc();
        if_req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            #1;
            vec++;
            if ({mem_req, if_valid} !== 2'b10) begin
                bad++;
                $display("FAIL to_wait cyc %0d got %b want 10",
                         k, {mem_req, if_valid});
            end
            cyc();
        end
        #1;
        vec++;
        if ({mem_req, if_valid, if_err, busy} !== 4'b0110
            || if_rdata !== '0) begin
            bad++;
            $display("FAIL to_abort got %b %h want 0110 0",
                     {mem_req, if_valid, if_err, busy}, if_rdata);
        end
        lat    = 0;
        rd_val = 32'hA5A50001;
        cyc();
        d_req  = 1'b1;
        d_addr = 32'h104;
        #1;
        vec++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL to_next_gnt got %b want 1", d_gnt);
        end
        cyc();
        d_req = 1'b0;
        cyc();
        #1;
        vec++;
        if ({d_valid, d_err} !== 2'b10
            || d_rdata !== 32'hA5A50001) begin
            bad++;
            $display("FAIL to_next got %b %h want 10 a5a50001",
                     {d_valid, d_err}, d_rdata);
        end
    endtask

    task automatic test_reset_mid();
        lat = -1;
        cyc();
        d_req  = 1'b1;
        d_addr = 32'h300;
        #1;
        vec++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rm_gnt got %b want 1", d_gnt);
        end
        cyc();
        d_req = 1'b0;
        cyc();
        vec++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rm_req got %b want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if ({mem_req, busy, d_valid, if_valid} !== 4'b0
            || mem_addr !== '0) begin
            bad++;
            $display("FAIL rm_clear got %b %h want 0000 0",
                     {mem_req, busy, d_valid, if_valid}, mem_addr);
        end
        cyc();
        rst_n = 1'b1;
        lat   = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            vec++;
            if ({d_valid, mem_req, busy} !== 3'b000) begin
                bad++;
                $display("FAIL rm_after cyc %0d got %b want 000",
                         k, {d_valid, mem_req, busy});
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_arbitration();
        test_bad_access();
        test_write();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, bad);
        $finish;
    end

endmodule
